rmst_arbiter: RTL and testbench

RMST_ARBITER -- requirements
Module: rmst_arbiter

---
 rtl/rmst_arbiter.sv | 155 +++++++++++++++
 tb/tb_rmst_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmst_arbiter.sv
// Round-robin arbiter that shares one AXI read master between the IFM and WGT buffers.
// Optional performance counters are built only when RMST_ARB_PERF_EN is defined.
module rmst_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifm_req,
  input  logic                  wgt_req,
  input  logic [ADDR_WIDTH-1:0] ifm_addr_base,
  input  logic [ADDR_WIDTH-1:0] wgt_addr_base,
  input  logic [ADDR_WIDTH-1:0] ifm_offset,
  input  logic [ADDR_WIDTH-1:0] wgt_offset,
  input  logic [ADDR_WIDTH-1:0] ifm_xfer_size,
  input  logic [ADDR_WIDTH-1:0] wgt_xfer_size,
  output logic                  ifm_done,
  output logic                  wgt_done,
  output logic                  rmst_start,
  output logic [ADDR_WIDTH-1:0] rmst_addr,
  output logic [ADDR_WIDTH-1:0] rmst_size,
  input  logic                  rmst_done,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  ifm_tvalid,
  input  logic                  ifm_tready,
  output logic [DATA_WIDTH-1:0] ifm_tdata,
  output logic                  wgt_tvalid,
  input  logic                  wgt_tready,
  output logic [DATA_WIDTH-1:0] wgt_tdata,
  output logic                  busy,
  output logic [1:0]            grant,
  output logic [31:0]           perf_ifm_grants,
  output logic [31:0]           perf_wgt_grants,
  output logic [31:0]           perf_wait_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            mask_q, mask_d;
  logic                  last_wgt_q, last_wgt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] size_q, size_d;
  logic                  ifm_eff, wgt_eff, pick_wgt, new_grant;

  // mask_q holds the requester served last, blocked for exactly one IDLE cycle
  assign ifm_eff   = ifm_req & ~mask_q[0];
  assign wgt_eff   = wgt_req & ~mask_q[1];
  assign pick_wgt  = wgt_eff & (~ifm_eff | ~last_wgt_q);
  assign new_grant = (state_q == IDLE) && (ifm_eff || wgt_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      mask_q     <= 2'b00;
      last_wgt_q <= 1'b1;
      addr_q     <= '0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mask_q     <= mask_d;
      last_wgt_q <= last_wgt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mask_d     = mask_q;
    last_wgt_d = last_wgt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    case (state_q)
      IDLE: begin
        mask_d = 2'b00;
        if (new_grant) begin
          state_d = ISSUE;
          grant_d = pick_wgt ? 2'b10 : 2'b01;
          addr_d  = pick_wgt ? (wgt_addr_base + wgt_offset) : (ifm_addr_base + ifm_offset);
          size_d  = pick_wgt ? wgt_xfer_size : ifm_xfer_size;
        end
      end
      ISSUE:   state_d = rmst_done ? DONE : XFER;
      XFER:    if (rmst_done) state_d = DONE;
      DONE: begin
        state_d    = IDLE;
        grant_d    = 2'b00;
        mask_d     = grant_q;
        last_wgt_d = grant_q[1];
      end
      default: state_d = IDLE;
    endcase
  end

  logic route;
  assign route = (state_q == ISSUE) || (state_q == XFER);

  always_comb begin
    busy       = (state_q != IDLE);
    grant      = grant_q;
    rmst_start = (state_q == ISSUE);
    rmst_addr  = addr_q;
    rmst_size  = size_q;
    ifm_done   = (state_q == DONE) && grant_q[0];
    wgt_done   = (state_q == DONE) && grant_q[1];
    ifm_tvalid = route && grant_q[0] && s_tvalid;
    wgt_tvalid = route && grant_q[1] && s_tvalid;
    s_tready   = route && ((grant_q[0] && ifm_tready) || (grant_q[1] && wgt_tready));
    ifm_tdata  = s_tdata;
    wgt_tdata  = s_tdata;
  end

`ifdef RMST_ARB_PERF_EN
  logic [31:0] perf_ifm_q, perf_ifm_d;
  logic [31:0] perf_wgt_q, perf_wgt_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic        waiting;

  assign waiting = (ifm_req && !grant_q[0]) || (wgt_req && !grant_q[1]);

  always_comb begin
    perf_ifm_d  = perf_ifm_q + 32'(new_grant && !pick_wgt);
    perf_wgt_d  = perf_wgt_q + 32'(new_grant && pick_wgt);
    perf_wait_d = perf_wait_q + 32'(waiting);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ifm_q  <= '0;
      perf_wgt_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_ifm_q  <= perf_ifm_d;
      perf_wgt_q  <= perf_wgt_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_ifm_grants  = perf_ifm_q;
  assign perf_wgt_grants  = perf_wgt_q;
  assign perf_wait_cycles = perf_wait_q;
`else
  assign perf_ifm_grants  = 32'd0;
  assign perf_wgt_grants  = 32'd0;
  assign perf_wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_rmst_arbiter.sv
// Self-checking bench for rmst_arbiter: launch and beat scoreboards plus per-scenario tasks.
module tb_rmst_arbiter;
  localparam int DW = 512;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifm_req, wgt_req;
  logic [AW-1:0] ifm_addr_base, wgt_addr_base, ifm_offset, wgt_offset;
  logic [AW-1:0] ifm_xfer_size, wgt_xfer_size;
  logic          ifm_done, wgt_done, rmst_start;
  logic [AW-1:0] rmst_addr, rmst_size;
  logic          rmst_done;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] s_tdata;
  logic          ifm_tvalid, ifm_tready, wgt_tvalid, wgt_tready;
  logic [DW-1:0] ifm_tdata, wgt_tdata;
  logic          busy;
  logic [1:0]    grant;
  logic [31:0]   perf_ifm_grants, perf_wgt_grants, perf_wait_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] size;
    logic [1:0]    grant;
  } launch_t;

  typedef struct {
    logic          to_wgt;
    logic [DW-1:0] data;
  } beat_t;

  launch_t launch_q[$];
  beat_t   beat_q[$];

  rmst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .ifm_req(ifm_req), .wgt_req(wgt_req),
    .ifm_addr_base(ifm_addr_base), .wgt_addr_base(wgt_addr_base),
    .ifm_offset(ifm_offset), .wgt_offset(wgt_offset),
    .ifm_xfer_size(ifm_xfer_size), .wgt_xfer_size(wgt_xfer_size),
    .ifm_done(ifm_done), .wgt_done(wgt_done),
    .rmst_start(rmst_start), .rmst_addr(rmst_addr), .rmst_size(rmst_size),
    .rmst_done(rmst_done),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .ifm_tvalid(ifm_tvalid), .ifm_tready(ifm_tready), .ifm_tdata(ifm_tdata),
    .wgt_tvalid(wgt_tvalid), .wgt_tready(wgt_tready), .wgt_tdata(wgt_tdata),
    .busy(busy), .grant(grant),
    .perf_ifm_grants(perf_ifm_grants), .perf_wgt_grants(perf_wgt_grants),
    .perf_wait_cycles(perf_wait_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Launch scoreboard: every rmst_start pulse must match the oldest expected launch.
  always @(negedge clk) begin
    launch_t le;
    if (!rst && rmst_start) begin
      n_checks++;
      if (launch_q.size() == 0) begin
        n_fail++;
        $display("FAIL launch_unexpected: got addr=%h size=%h grant=%b, required no launch",
                 rmst_addr, rmst_size, grant);
      end else begin
        le = launch_q.pop_front();
        if (rmst_addr !== le.addr || rmst_size !== le.size || grant !== le.grant) begin
          n_fail++;
          $display("FAIL launch: got addr=%h size=%h grant=%b, required addr=%h size=%h grant=%b",
                   rmst_addr, rmst_size, grant, le.addr, le.size, le.grant);
        end else
          $display("launch addr=%h size=%h grant=%b ok", rmst_addr, rmst_size, grant);
      end
    end
  end

  // Beat scoreboard: every downstream handshake must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t be;
    logic  hs_i, hs_w;
    hs_i = ifm_tvalid && ifm_tready;
    hs_w = wgt_tvalid && wgt_tready;
    if (!rst && (hs_i || hs_w)) begin
      n_checks++;
      if (beat_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got ifm_hs=%b wgt_hs=%b, required no beat", hs_i, hs_w);
      end else begin
        be = beat_q.pop_front();
        if (hs_i === be.to_wgt || hs_w !== be.to_wgt ||
            (be.to_wgt ? wgt_tdata : ifm_tdata) !== be.data) begin
          n_fail++;
          $display("FAIL beat: got wgt_hs=%b data=%h, required wgt_hs=%b data=%h",
                   hs_w, be.to_wgt ? wgt_tdata : ifm_tdata, be.to_wgt, be.data);
        end else
          $display("beat to_wgt=%b ok", be.to_wgt);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    ifm_req = 0; wgt_req = 0; rmst_done = 0; s_tvalid = 0; s_tdata = '0;
    ifm_tready = 1; wgt_tready = 1;
    tick; tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic push_launch(input logic [AW-1:0] a, input logic [AW-1:0] s, input logic [1:0] g);
    launch_t le;
    le.addr = a; le.size = s; le.grant = g;
    launch_q.push_back(le);
  endtask

  // Pulses rmst_done, samples both done outputs in DONE, returns in the following IDLE cycle.
  task automatic complete(output logic got_ifm, output logic got_wgt);
    rmst_done = 1'b1;
    tick;
    got_ifm = ifm_done;
    got_wgt = wgt_done;
    rmst_done = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifm_req = 1; wgt_req = 1; rmst_done = 0; s_tvalid = 1; s_tdata = '1;
    ifm_tready = 1; wgt_tready = 1;
    tick; tick;
    n_checks++;
    if ({busy, grant, rmst_start, ifm_done, wgt_done, s_tready, ifm_tvalid, wgt_tvalid} !== 9'b0 ||
        rmst_addr !== '0 || rmst_size !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b grant=%b start=%b done=%b%b tready=%b tvalid=%b%b addr=%h size=%h, required all 0",
               busy, grant, rmst_start, ifm_done, wgt_done, s_tready, ifm_tvalid, wgt_tvalid, rmst_addr, rmst_size);
    end
    n_checks++;
    if ({perf_ifm_grants, perf_wgt_grants, perf_wait_cycles} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d %0d %0d, required 0 0 0",
               perf_ifm_grants, perf_wgt_grants, perf_wait_cycles);
    end
    $display("reset checked");
    apply_reset;
  endtask

  task automatic test_single_ifm;
    logic gi, gw;
    apply_reset;
    ifm_addr_base = 64'h1000; ifm_offset = 64'h40; ifm_xfer_size = 64'h200;
    push_launch(64'h1040, 64'h200, 2'b01);
    ifm_req = 1'b1;
    tick;
    n_checks++;
    if (rmst_start !== 1'b1 || grant !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: got start=%b grant=%b busy=%b, required 1 01 1", rmst_start, grant, busy);
    end
    ifm_req = 1'b0;
    tick;
    n_checks++;
    if (rmst_start !== 1'b0 || busy !== 1'b1 || grant !== 2'b01) begin
      n_fail++;
      $display("FAIL single_xfer: got start=%b busy=%b grant=%b, required 0 1 01", rmst_start, busy, grant);
    end
    complete(gi, gw);
    n_checks++;
    if (gi !== 1'b1 || gw !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got ifm_done=%b wgt_done=%b, required 1 0", gi, gw);
    end
    n_checks++;
    if (ifm_done !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 || rmst_addr !== 64'h1040) begin
      n_fail++;
      $display("FAIL single_idle: got done=%b busy=%b grant=%b addr=%h, required 0 0 00 1040",
               ifm_done, busy, grant, rmst_addr);
    end
    n_checks++;
    if (launch_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_launch_seen: got %0d pending, required 0", launch_q.size());
    end
    $display("single ifm transfer checked");
  endtask

  task automatic test_round_robin;
    logic gi, gw;
    apply_reset;
    ifm_addr_base = 64'h2000; ifm_offset = 64'h10; ifm_xfer_size = 64'h100;
    wgt_addr_base = 64'h8000; wgt_offset = 64'h08; wgt_xfer_size = 64'h300;
    push_launch(64'h2010, 64'h100, 2'b01);
    ifm_req = 1; wgt_req = 1;
    tick;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first: got grant=%b, required 01", grant);
    end
    tick;
    push_launch(64'h8008, 64'h300, 2'b10);
    complete(gi, gw);
    n_checks++;
    if (gi !== 1'b1 || gw !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_ifm_done: got %b%b, required ifm=1 wgt=0", gi, gw);
    end
    tick;
    n_checks++;
    if (grant !== 2'b10 || rmst_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_second: got grant=%b start=%b, required 10 1", grant, rmst_start);
    end
    push_launch(64'h2010, 64'h100, 2'b01);
    complete(gi, gw);
    n_checks++;
    if (gi !== 1'b0 || gw !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_wgt_done: got %b%b, required ifm=0 wgt=1", gi, gw);
    end
    tick;
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_third: got grant=%b, required 01", grant);
    end
    ifm_req = 0; wgt_req = 0;
    complete(gi, gw);
    n_checks++;
    if (launch_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got pending=%0d busy=%b, required 0 0", launch_q.size(), busy);
    end
    $display("round robin checked");
  endtask

  task automatic test_wgt_beats;
    logic          gi, gw;
    logic [DW-1:0] beats [4];
    int            k;
    beat_t         be;
    apply_reset;
    wgt_addr_base = 64'h4000; wgt_offset = 64'h0; wgt_xfer_size = 64'h100;
    push_launch(64'h4000, 64'h100, 2'b10);
    wgt_req = 1;
    tick;
    wgt_req = 0;
    tick;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < DW / 32; w++) beats[b][w*32 +: 32] = $urandom();
      be.to_wgt = 1'b1; be.data = beats[b];
      beat_q.push_back(be);
    end
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      s_tvalid = 1'b1;
      s_tdata = beats[k];
      wgt_tready = cyc[0];
      ifm_tready = 1'b1;
      #1;
      n_checks++;
      if (s_tready !== wgt_tready || ifm_tvalid !== 1'b0 || wgt_tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL beats_route: got s_tready=%b ifm_tvalid=%b wgt_tvalid=%b, required %b 0 1",
                 s_tready, ifm_tvalid, wgt_tvalid, wgt_tready);
      end
      if (wgt_tready) k++;
      tick;
    end
    s_tvalid = 1'b0;
    n_checks++;
    if (k != 4 || beat_q.size() != 0) begin
      n_fail++;
      $display("FAIL beats_count: got sent=%0d pending=%0d, required 4 0", k, beat_q.size());
    end
    complete(gi, gw);
    n_checks++;
    if (gw !== 1'b1 || gi !== 1'b0) begin
      n_fail++;
      $display("FAIL beats_done: got ifm=%b wgt=%b, required 0 1", gi, gw);
    end
    $display("wgt beats checked");
  endtask

  task automatic test_done_timing;
    int pulses;
    apply_reset;
    rmst_done = 1'b1;
    tick;
    n_checks++;
    if (busy !== 1'b0 || ifm_done !== 1'b0 || wgt_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_idle: got busy=%b done=%b%b, required 0 00", busy, ifm_done, wgt_done);
    end
    rmst_done = 1'b0;
    ifm_addr_base = 64'h0; ifm_offset = 64'h80; ifm_xfer_size = 64'h40;
    push_launch(64'h80, 64'h40, 2'b01);
    ifm_req = 1'b1;
    tick;
    ifm_req = 1'b0;
    rmst_done = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (c == 0) rmst_done = 1'b0;
      if (ifm_done === 1'b1) pulses++;
      if (c == 0) begin
        n_checks++;
        if (ifm_done !== 1'b1) begin
          n_fail++;
          $display("FAIL done_from_issue: got ifm_done=%b, required 1", ifm_done);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_once: got pulses=%0d busy=%b, required 1 0", pulses, busy);
    end
    $display("done timing checked");
  endtask

  task automatic test_addr_wrap;
    logic gi, gw;
    apply_reset;
    wgt_addr_base = 64'hFFFF_FFFF_FFFF_FFF0; wgt_offset = 64'h20; wgt_xfer_size = 64'h80;
    push_launch(64'h10, 64'h80, 2'b10);
    wgt_req = 1'b1;
    tick;
    wgt_req = 1'b0;
    n_checks++;
    if (rmst_addr !== 64'h10) begin
      n_fail++;
      $display("FAIL addr_wrap: got %h, required 0000000000000010", rmst_addr);
    end
    complete(gi, gw);
    n_checks++;
    if (gw !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_wrap_done: got wgt_done=%b, required 1", gw);
    end
    $display("address wrap checked");
  endtask

  task automatic test_reset_mid_xfer;
    logic gi, gw;
    int   pulses;
    apply_reset;
    ifm_addr_base = 64'h3000; ifm_offset = 64'h0; ifm_xfer_size = 64'h20;
    wgt_addr_base = 64'h5000; wgt_offset = 64'h0; wgt_xfer_size = 64'h40;
    push_launch(64'h3000, 64'h20, 2'b01);
    ifm_req = 1'b1;
    tick; tick;
    rst = 1'b1;
    wgt_req = 1'b1;
    pulses = 0;
    tick;
    if (ifm_done === 1'b1 || wgt_done === 1'b1) pulses++;
    n_checks++;
    if (busy !== 1'b0 || grant !== 2'b00 || rmst_addr !== '0 || s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b grant=%b addr=%h s_tready=%b, required 0 00 0 0",
               busy, grant, rmst_addr, s_tready);
    end
    tick;
    if (ifm_done === 1'b1 || wgt_done === 1'b1) pulses++;
    rst = 1'b0;
    push_launch(64'h3000, 64'h20, 2'b01);
    tick;
    n_checks++;
    if (grant !== 2'b01 || pulses != 0) begin
      n_fail++;
      $display("FAIL rst_regrant: got grant=%b done_pulses=%0d, required 01 0", grant, pulses);
    end
    tick;
`ifdef RMST_ARB_PERF_EN
    n_checks++;
    if (perf_wait_cycles !== 32'd2 || perf_ifm_grants !== 32'd1 || perf_wgt_grants !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_counts: got wait=%0d ifm=%0d wgt=%0d, required 2 1 0",
               perf_wait_cycles, perf_ifm_grants, perf_wgt_grants);
    end
`else
    n_checks++;
    if ({perf_ifm_grants, perf_wgt_grants, perf_wait_cycles} !== 96'd0) begin
      n_fail++;
      $display("FAIL perf_tied: got %0d %0d %0d, required 0 0 0",
               perf_ifm_grants, perf_wgt_grants, perf_wait_cycles);
    end
`endif
    push_launch(64'h5000, 64'h40, 2'b10);
    complete(gi, gw);
    tick;
    n_checks++;
    if (gi !== 1'b1 || grant !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_then_wgt: got ifm_done=%b grant=%b, required 1 10", gi, grant);
    end
    ifm_req = 0; wgt_req = 0;
    complete(gi, gw);
    n_checks++;
    if (gw !== 1'b1 || launch_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_drain: got wgt_done=%b pending=%0d, required 1 0", gw, launch_q.size());
    end
    $display("reset mid transfer checked");
  endtask

  initial begin
    ifm_addr_base = '0; wgt_addr_base = '0; ifm_offset = '0; wgt_offset = '0;
    ifm_xfer_size = '0; wgt_xfer_size = '0;
    test_reset;
    test_single_ifm;
    test_round_robin;
    test_wgt_beats;
    test_done_timing;
    test_addr_wrap;
    test_reset_mid_xfer;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
